// File: rtl/mem_access_stage.sv
// MEM pipeline stage: forwards ALU results to writeback, or runs one lw/sw
// request/ready transaction on the data-memory port with misalignment and timeout detection.
module mem_access_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_lw,
  input  logic        ex_sw,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic is_mem;
  logic misaligned;
  logic timeout_hit;

  assign is_mem      = ex_lw | ex_sw;
  assign misaligned  = ex_alu_result[1:0] != 2'b00;
  // The counter only advances on cycles without dmem_ready, so ready always beats the timeout.
  assign timeout_hit = (state_q == ACCESS) && !dmem_ready && (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ex_valid && is_mem && !misaligned) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ready || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = 8'd0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    req_d       = 1'b0;
    we_d        = we_q;
    wb_valid_d  = 1'b0;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_d  = 1'b1;
            wb_result_d = ex_alu_result;
            wb_rd_d     = ex_rd;
            wb_rw_d     = ex_reg_write;
          end else if (misaligned) begin
            wb_valid_d  = 1'b1;
            wb_result_d = ex_alu_result;
            wb_rd_d     = ex_rd;
            wb_rw_d     = 1'b0;
            misalign_d  = 1'b1;
          end else begin
            addr_d  = {ex_alu_result[31:2], 2'b00};
            wdata_d = ex_store_data;
            rd_d    = ex_rd;
            rw_d    = ex_reg_write;
            req_d   = 1'b1;
            // lw takes priority when both op bits are set.
            we_d    = ~ex_lw;
          end
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (!we_q) begin
            wb_result_d = dmem_rdata;
            wb_rw_d     = rw_q;
          end else begin
            wb_result_d = addr_q;
            wb_rw_d     = 1'b0;
          end
        end else if (timeout_hit) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_rw_d    = 1'b0;
          bus_err_d  = 1'b1;
        end else begin
          req_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 8'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rd_q        <= 5'd0;
      rw_q        <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= 32'd0;
      wb_rd_q     <= 5'd0;
      wb_rw_q     <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      req_q       <= req_d;
      we_q        <= we_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_result    = wb_result_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_rw_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized bench for mem_access_stage against a transaction-level model
// (memory latency -> completion cycle count, result and error flags).
module tb_mem_access_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_lw;
  logic        ex_sw;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int fails  = 0;

  // Last value WB is expected to hold while wb_valid=0.
  logic [31:0] hold_result;
  logic [4:0]  hold_rd;
  bit          hold_known;

  mem_access_stage #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_lw(ex_lw), .ex_sw(ex_sw),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_flags(input string tag);
    chk({tag, " ex_ready"}, 32'(ex_ready), 32'd1);
    chk({tag, " dmem_req"}, 32'(dmem_req), 32'd0);
  endtask

  task automatic do_idle();
    ex_valid = 1'b0;
    step();
    chk("idle wb_valid", 32'(wb_valid), 32'd0);
    chk("idle misalign", 32'(misalign_err), 32'd0);
    chk("idle bus_err", 32'(bus_err), 32'd0);
    chk_idle_flags("idle");
    if (hold_known) begin
      chk("idle wb_result hold", wb_result, hold_result);
      chk("idle wb_rd hold", 32'(wb_rd), 32'(hold_rd));
    end
  endtask

  task automatic do_alu(input logic [31:0] res, input logic [4:0] rd, input bit rw);
    chk("alu ex_ready", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_alu_result = res; ex_rd = rd; ex_reg_write = rw;
    ex_lw = 1'b0; ex_sw = 1'b0; ex_store_data = $urandom;
    step();
    ex_valid = 1'b0;
    chk("alu wb_valid", 32'(wb_valid), 32'd1);
    chk("alu wb_result", wb_result, res);
    chk("alu wb_rd", 32'(wb_rd), 32'(rd));
    chk("alu wb_reg_write", 32'(wb_reg_write), 32'(rw));
    chk("alu misalign", 32'(misalign_err), 32'd0);
    chk_idle_flags("alu");
    hold_result = res; hold_rd = rd; hold_known = 1'b1;
  endtask

  // lat: ACCESS cycle (1-based) on which memory answers; 0 = never answers.
  task automatic do_mem(input bit lw, input bit sw, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input int lat, input bit rw, input logic [4:0] rd);
    bit is_store;
    bit done_ok;
    int n;
    is_store = !lw;
    chk("mem ex_ready", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_alu_result = addr; ex_store_data = data; ex_rd = rd;
    ex_reg_write = rw; ex_lw = lw; ex_sw = sw;
    step();
    if (addr[1:0] != 2'b00) begin
      ex_valid = 1'b0;
      chk("mis wb_valid", 32'(wb_valid), 32'd1);
      chk("mis wb_reg_write", 32'(wb_reg_write), 32'd0);
      chk("mis misalign_err", 32'(misalign_err), 32'd1);
      chk("mis bus_err", 32'(bus_err), 32'd0);
      chk_idle_flags("mis");
      hold_known = 1'b0;
      return;
    end
    done_ok = (lat != 0) && (lat <= T);
    n = done_ok ? lat : T;
    for (int c = 1; c <= n; c++) begin
      chk("acc dmem_req", 32'(dmem_req), 32'd1);
      chk("acc ex_ready", 32'(ex_ready), 32'd0);
      chk("acc dmem_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("acc dmem_we", 32'(dmem_we), 32'(is_store));
      if (is_store) chk("acc dmem_wdata", dmem_wdata, data);
      chk("acc wb_valid", 32'(wb_valid), 32'd0);
      // Unrelated EX traffic during ACCESS must be ignored.
      ex_valid = 1'($urandom); ex_alu_result = $urandom; ex_rd = 5'($urandom);
      ex_lw = 1'($urandom); ex_sw = 1'($urandom); ex_reg_write = 1'($urandom);
      dmem_ready = (c == lat);
      dmem_rdata = (c == lat) ? rdata : $urandom;
      step();
    end
    ex_valid = 1'b0;
    dmem_ready = 1'b0;
    chk("done wb_valid", 32'(wb_valid), 32'd1);
    chk("done bus_err", 32'(bus_err), 32'(!done_ok));
    chk("done misalign", 32'(misalign_err), 32'd0);
    chk("done wb_reg_write", 32'(wb_reg_write), 32'(done_ok && !is_store && rw));
    chk_idle_flags("done");
    if (done_ok) begin
      chk("done wb_result", wb_result, is_store ? addr : rdata);
      chk("done wb_rd", 32'(wb_rd), 32'(rd));
      hold_result = is_store ? addr : rdata; hold_rd = rd; hold_known = 1'b1;
    end else begin
      hold_known = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_lw = 1'b0; ex_sw = 1'b0; dmem_rdata = '0; dmem_ready = 1'b0;
    step();
    step();
    chk("rst ex_ready", 32'(ex_ready), 32'd1);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst dmem_we", 32'(dmem_we), 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    chk("rst dmem_wdata", dmem_wdata, 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst wb_result", wb_result, 32'd0);
    chk("rst wb_rd", 32'(wb_rd), 32'd0);
    chk("rst wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst misalign", 32'(misalign_err), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    rst_n = 1'b1;
    hold_result = '0; hold_rd = '0; hold_known = 1'b1;
    do_idle();

    do_alu(32'h0000_0005, 5'd3, 1'b1);
    do_alu(32'h1234_5678, 5'd7, 1'b0);
    do_idle();
    do_mem(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 5'd9);
    do_idle();
    do_mem(1'b0, 1'b1, 32'h0000_0104, 32'hA5A5_A5A5, 32'h0, 1, 1'b1, 5'd4);
    do_mem(1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 1, 1'b1, 5'd5);
    do_idle();
    do_mem(1'b0, 1'b1, 32'h0000_0200, 32'h1111_2222, 32'h0, 0, 1'b0, 5'd6);
    do_idle();
    do_mem(1'b0, 1'b1, 32'h0000_0204, 32'h3333_4444, 32'h0, T, 1'b0, 5'd6);
    do_idle();
    do_mem(1'b1, 1'b1, 32'h0000_0300, 32'h5555_6666, 32'hCAFE_F00D, 2, 1'b1, 5'd12);
    do_idle();

    // Reset in the second ACCESS cycle of a lw.
    ex_valid = 1'b1; ex_alu_result = 32'h0000_0400; ex_rd = 5'd8; ex_reg_write = 1'b1;
    ex_lw = 1'b1; ex_sw = 1'b0;
    step();
    ex_valid = 1'b0;
    step();
    chk("rstacc dmem_req before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstacc dmem_req", 32'(dmem_req), 32'd0);
    chk("rstacc ex_ready", 32'(ex_ready), 32'd1);
    chk("rstacc wb_valid", 32'(wb_valid), 32'd0);
    step();
    chk("rstacc wb_valid later", 32'(wb_valid), 32'd0);
    rst_n = 1'b1;
    hold_result = '0; hold_rd = '0; hold_known = 1'b1;
    do_idle();
    do_alu(32'h0000_00AA, 5'd1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      a = $urandom;
      case (kind)
        0: do_alu(a, 5'($urandom), 1'($urandom));
        1: do_mem(1'b1, 1'($urandom), {a[31:2], 2'b00}, $urandom, $urandom,
                  int'($urandom_range(0, T + 2)), 1'($urandom), 5'($urandom));
        2: do_mem(1'b0, 1'b1, {a[31:2], 2'b00}, $urandom, $urandom,
                  int'($urandom_range(0, T + 2)), 1'($urandom), 5'($urandom));
        default: do_mem(1'($urandom), 1'b1, {a[31:2], 2'(int'($urandom_range(1, 3)))},
                        $urandom, $urandom, 1, 1'($urandom), 5'($urandom));
      endcase
      if ($urandom_range(0, 2) == 0) do_idle();
    end
    do_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
